// File: rtl/param_stack.sv
// Parametrised synchronous LIFO stack with split data ports, occupancy status,
// error pulses and a synchronous flush. Replace-top on simultaneous push and pop.
module param_stack #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = 1020,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          pop_ok;
    logic          push_ok;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] count_nxt;

    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] c,
                                                 input logic          do_push,
                                                 input logic          do_pop);
        logic [CW-1:0] n;
        n = c;
        if (do_push && !do_pop)
            n = c + CW'(1);
        else if (do_pop && !do_push)
            n = c - CW'(1);
        return n;
    endfunction

    // A push alongside an accepted pop overwrites the top slot, so it is never
    // refused for fullness; a push alongside a rejected pop lands at slot 0.
    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (pop || !full);
        rd_addr   = AW'(count - CW'(1));
        wr_addr   = pop_ok ? rd_addr : AW'(count);
        count_nxt = next_count(count, push_ok, pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rst && !clr && push_ok)
            mem[wr_addr] <= data_in;
    end

    // Read and write of the same slot in one edge returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            data_out    <= '0;
        end else if (clr) begin
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == DEPTH_C);
            almost_full <= (count_nxt >= AF_C);
            out_valid   <= pop_ok;
            overflow    <= push && !pop && full;
            underflow   <= pop && empty;
            if (pop_ok)
                data_out <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack: directed scenarios plus randomized traffic
// against a queue-based LIFO model, and a DEPTH=1024 fill/drain regression.
module tb_param_stack;

    localparam int D   = 8;
    localparam int AF  = 6;
    localparam int DB  = 1024;
    localparam int AFB = 1020;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] data_out;
    logic       out_valid, empty, full, almost_full, overflow, underflow;
    logic [3:0] count;

    logic        b_rst = 1'b0, b_clr = 1'b0, b_push = 1'b0, b_pop = 1'b0;
    logic [7:0]  b_din = '0;
    logic [7:0]  b_data_out;
    logic        b_out_valid, b_empty, b_full, b_almost_full, b_overflow, b_underflow;
    logic [10:0] b_count;

    param_stack #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop), .data_in(din),
        .data_out(data_out), .out_valid(out_valid), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    param_stack #(.WIDTH(8), .DEPTH(DB), .AF_LEVEL(AFB)) dut_big (
        .clk(clk), .rst(b_rst), .clr(b_clr), .push(b_push), .pop(b_pop), .data_in(b_din),
        .data_out(b_data_out), .out_valid(b_out_valid), .empty(b_empty), .full(b_full),
        .almost_full(b_almost_full), .count(b_count), .overflow(b_overflow), .underflow(b_underflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a plain queue whose back is the top of the stack.
    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    bit         m_vld, m_ov, m_uf;

    task automatic cyc(input bit r, input bit c, input bit p, input bit po, input logic [7:0] d);
        rst = r; clr = c; push = p; pop = po; din = d;
        @(posedge clk);
        m_vld = 0; m_ov = 0; m_uf = 0;
        if (r) begin
            q.delete();
            m_dout = '0;
        end else if (c) begin
            q.delete();
        end else begin
            if (po && q.size() == 0) m_uf = 1;
            if (p && !po && q.size() == D) m_ov = 1;
            if (po && q.size() > 0) begin
                m_dout = q.pop_back();
                m_vld  = 1;
            end
            if (p && q.size() < D) q.push_back(d);
        end
        #1;
        rst = 0; clr = 0; push = 0; pop = 0;
    endtask

    task automatic test_reset();
        repeat (3) cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 8'h00);
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++; $display("FAIL reset_status: empty=%b count=%0d expected empty=1 count=0", empty, count);
        end
        n_checks++;
        if (data_out !== 8'h00) begin
            n_fail++; $display("FAIL reset_dout: data_out=%h expected 00", data_out);
        end
        n_checks++;
        if ({full, almost_full, out_valid, overflow, underflow} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: full/af/vld/ov/uf=%b expected 00000",
                               {full, almost_full, out_valid, overflow, underflow});
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 1, 0, 8'(2 * i));
            n_checks++;
            if (count !== 4'(i + 1) || almost_full !== ((i + 1) >= AF) || full !== (i == D - 1)) begin
                n_fail++; $display("FAIL fill_%0d: count=%0d af=%b full=%b expected count=%0d af=%b full=%b",
                                   i, count, almost_full, full, i + 1, (i + 1) >= AF, i == D - 1);
            end
        end
        cyc(0, 0, 1, 0, 8'hFF);
        n_checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            n_fail++; $display("FAIL overflow: overflow=%b count=%0d expected 1 and 8", overflow, count);
        end
        cyc(0, 0, 0, 0, 8'h00);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL overflow_pulse: overflow=%b expected 0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 0, 1, 8'h00);
            n_checks++;
            if (data_out !== 8'(14 - 2 * i) || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL drain_%0d: data_out=%0d vld=%b expected %0d vld=1",
                                   i, data_out, out_valid, 14 - 2 * i);
            end
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            n_fail++; $display("FAIL drain_empty: empty=%b count=%0d expected 1 and 0", empty, count);
        end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (underflow !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h00) begin
            n_fail++; $display("FAIL underflow: uf=%b vld=%b data_out=%h expected 1 0 00",
                               underflow, out_valid, data_out);
        end
    endtask

    task automatic test_replace_top();
        cyc(0, 0, 1, 0, 8'hA1);
        cyc(0, 0, 1, 0, 8'hB2);
        cyc(0, 0, 1, 1, 8'hC3);
        n_checks++;
        if (data_out !== 8'hB2 || out_valid !== 1'b1 || count !== 4'd2) begin
            n_fail++; $display("FAIL replace: data_out=%h vld=%b count=%0d expected B2 1 2",
                               data_out, out_valid, count);
        end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (data_out !== 8'hC3) begin
            n_fail++; $display("FAIL replace_pop1: data_out=%h expected C3", data_out);
        end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (data_out !== 8'hA1 || empty !== 1'b1) begin
            n_fail++; $display("FAIL replace_pop2: data_out=%h empty=%b expected A1 1", data_out, empty);
        end
    endtask

    task automatic test_full_and_empty_pushpop();
        for (int i = 0; i < D; i++) cyc(0, 0, 1, 0, 8'(2 * i));
        cyc(0, 0, 1, 1, 8'h55);
        n_checks++;
        if (data_out !== 8'd14 || count !== 4'd8 || overflow !== 1'b0 || full !== 1'b1) begin
            n_fail++; $display("FAIL full_pushpop: data_out=%0d count=%0d ov=%b full=%b expected 14 8 0 1",
                               data_out, count, overflow, full);
        end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (data_out !== 8'h55 || count !== 4'd7) begin
            n_fail++; $display("FAIL full_pushpop_pop: data_out=%h count=%0d expected 55 7", data_out, count);
        end
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 0, 1, 1, 8'h77);
        n_checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h55) begin
            n_fail++; $display("FAIL empty_pushpop: count=%0d uf=%b vld=%b data_out=%h expected 1 1 0 55",
                               count, underflow, out_valid, data_out);
        end
        cyc(0, 0, 0, 1, 8'h00);
        n_checks++;
        if (data_out !== 8'h77 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL empty_pushpop_pop: data_out=%h vld=%b expected 77 1", data_out, out_valid);
        end
    endtask

    task automatic test_clr_rst();
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'(i + 1));
        cyc(0, 1, 1, 0, 8'hEE);
        n_checks++;
        if (count !== 4'd0 || empty !== 1'b1 || data_out !== 8'h77) begin
            n_fail++; $display("FAIL clr: count=%0d empty=%b data_out=%h expected 0 1 77", count, empty, data_out);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'(i + 8'h30));
        cyc(1, 0, 0, 1, 8'h00);
        n_checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || data_out !== 8'h00 || empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_pop: count=%0d vld=%b data_out=%h empty=%b expected 0 0 00 1",
                               count, out_valid, data_out, empty);
        end
    endtask

    task automatic test_random();
        logic [5:0] got, exp;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 199);
            cyc(r == 0, r == 1, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, 8'($urandom));
            got = {empty, full, almost_full, out_valid, overflow, underflow};
            exp = {q.size() == 0, q.size() == D, q.size() >= AF, m_vld, m_ov, m_uf};
            n_checks++;
            if (count !== 4'(q.size()) || got !== exp || data_out !== m_dout) begin
                n_fail++; $display("FAIL random_%0d: count=%0d flags=%b data_out=%h expected %0d %b %h",
                                   n, count, got, data_out, q.size(), exp, m_dout);
            end
        end
    endtask

    task automatic test_deep();
        b_rst = 1;
        repeat (2) @(posedge clk);
        #1 b_rst = 0;
        for (int i = 0; i < DB; i++) begin
            b_push = 1; b_din = 8'(i);
            @(posedge clk); #1;
        end
        b_push = 0;
        n_checks++;
        if (b_count !== 11'd1024 || b_full !== 1'b1 || b_almost_full !== 1'b1) begin
            n_fail++; $display("FAIL deep_fill: count=%0d full=%b af=%b expected 1024 1 1",
                               b_count, b_full, b_almost_full);
        end
        for (int i = 0; i < DB; i++) begin
            b_pop = 1;
            @(posedge clk); #1;
            n_checks++;
            if (b_data_out !== 8'(DB - 1 - i) || b_out_valid !== 1'b1) begin
                n_fail++; $display("FAIL deep_pop_%0d: data_out=%0d vld=%b expected %0d 1",
                                   i, b_data_out, b_out_valid, (DB - 1 - i) % 256);
            end
        end
        b_pop = 0;
        n_checks++;
        if (b_empty !== 1'b1 || b_count !== 11'd0) begin
            n_fail++; $display("FAIL deep_empty: empty=%b count=%0d expected 1 0", b_empty, b_count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_replace_top();
        test_full_and_empty_pushpop();
        test_clr_rst();
        test_random();
        test_deep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
